// File: rtl/gate_checker.sv
// gate_checker: drives the four input vectors {a,b} = 00,01,10,11 into an
// external two-input gate and checks its response y against the function
// chosen by sel. Each vector is held for SETTLE+1 cycles and y is sampled
// in the last of them.
//
// Ports:
//   clk        single clock, rising edge
//   rst_n      asynchronous active-low reset
//   start      one-cycle run request, honoured only in IDLE
//   sel[2:0]   expected function: 0 AND, 1 OR, 2 XOR, 3 NAND, 4 NOR,
//              5 XNOR, 6..7 invalid
//   a, b       registered stimulus to the gate under test
//   y          combinational response of the gate under test
//   busy       high while a run is in progress
//   done       one-cycle end-of-run pulse
//   pass       1 when all four vectors matched (held until next run)
//   fail_vec   bit i set when vector {a,b}=i mismatched (held)
//   err_count  number of set bits in fail_vec (held)
//
// state  | meaning
// IDLE   | waiting for start
// RUN    | driving vectors, settling, sampling y
// DONE   | one-cycle result pulse, then back to IDLE
module gate_checker #(
  parameter int unsigned SETTLE = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [2:0] sel,
  output logic       a,
  output logic       b,
  input  logic       y,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [3:0] fail_vec,
  output logic [2:0] err_count
);

  localparam logic [3:0] SETTLE_C = 4'(SETTLE);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  state_t     state, state_nxt;
  logic [2:0] sel_q;
  logic [1:0] idx;
  logic [3:0] settle_cnt;
  logic       sel_valid;
  logic       sample;
  logic       y_exp;
  logic       mism;
  logic [3:0] fail_vec_nxt;

  assign sel_valid = (sel < 3'd6);
  assign sample    = (state == S_RUN) && (settle_cnt == SETTLE_C);
  assign busy      = (state == S_RUN);
  assign done      = (state == S_DONE);

  always_comb begin
    y_exp = 1'b0;
    case (sel_q)
      3'd0:    y_exp = a & b;
      3'd1:    y_exp = a | b;
      3'd2:    y_exp = a ^ b;
      3'd3:    y_exp = ~(a & b);
      3'd4:    y_exp = ~(a | b);
      3'd5:    y_exp = ~(a ^ b);
      default: y_exp = 1'b0;
    endcase
  end

  assign mism         = sample && (y != y_exp);
  assign fail_vec_nxt = fail_vec | (mism ? (4'b0001 << idx) : 4'b0000);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: if (start) state_nxt = sel_valid ? S_RUN : S_DONE;
      S_RUN:  if (sample && (idx == 2'd3)) state_nxt = S_DONE;
      S_DONE: state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sel_q      <= 3'd0;
      idx        <= 2'd0;
      settle_cnt <= 4'd0;
      a          <= 1'b0;
      b          <= 1'b0;
      pass       <= 1'b0;
      fail_vec   <= 4'd0;
      err_count  <= 3'd0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            pass       <= 1'b0;
            idx        <= 2'd0;
            settle_cnt <= 4'd0;
            a          <= 1'b0;
            b          <= 1'b0;
            if (sel_valid) begin
              sel_q     <= sel;
              fail_vec  <= 4'd0;
              err_count <= 3'd0;
            end else begin
              // Invalid function: report every vector as failed, no run.
              fail_vec  <= 4'b1111;
              err_count <= 3'd4;
            end
          end
        end
        S_RUN: begin
          if (!sample) begin
            settle_cnt <= settle_cnt + 4'd1;
          end else begin
            fail_vec  <= fail_vec_nxt;
            err_count <= err_count + {2'b00, mism};
            if (idx != 2'd3) begin
              idx        <= idx + 2'd1;
              {a, b}     <= idx + 2'd1;
              settle_cnt <= 4'd0;
            end else begin
              a    <= 1'b0;
              b    <= 1'b0;
              pass <= (fail_vec_nxt == 4'd0);
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_gate_checker.sv
module tb_gate_checker;

  localparam int SETTLE = 2;
  localparam int RUN_LAT = 4 * (SETTLE + 1);

  logic       clk;
  logic       rst_n;
  logic       start;
  logic [2:0] sel;
  logic       a, b, y;
  logic       busy, done, pass;
  logic [3:0] fail_vec;
  logic [2:0] err_count;

  gate_checker #(.SETTLE(SETTLE)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .sel(sel),
    .a(a), .b(b), .y(y), .busy(busy), .done(done), .pass(pass),
    .fail_vec(fail_vec), .err_count(err_count)
  );

  // Gate under test: 0 AND,1 OR,2 XOR,3 NAND,4 NOR,5 XNOR,6 stuck-at-0
  int gmode;
  always_comb begin
    case (gmode)
      0: y = a & b;
      1: y = a | b;
      2: y = a ^ b;
      3: y = ~(a & b);
      4: y = ~(a | b);
      5: y = ~(a ^ b);
      default: y = 1'b0;
    endcase
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic       pass;
    logic [3:0] fv;
    logic [2:0] ec;
    int         cyc;
  } exp_t;

  exp_t exp_q[$];
  int total = 0;
  int bad = 0;
  int done_cnt = 0;

  task automatic check(input string name, input int act, input int req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, req);
    end
  endtask

  // Monitor: every done pulse is matched against the oldest expectation.
  always @(negedge clk) begin
    if (rst_n && done) begin
      done_cnt++;
      if (exp_q.size() == 0) begin
        check("unexpected_done", 1, 0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("pass", int'(pass), int'(e.pass));
        check("fail_vec", int'(fail_vec), int'(e.fv));
        check("err_count", int'(err_count), int'(e.ec));
        check("done_cycle", cyc, e.cyc);
        check("busy_in_done", int'(busy), 0);
      end
    end
  end

  // Issue one start; push the hand-computed result and done cycle.
  task automatic issue(input logic [2:0] s, input int g, input logic ep,
                       input logic [3:0] efv, input logic [2:0] eec);
    exp_t e;
    @(negedge clk);
    gmode = g;
    sel   = s;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    e.pass = ep;
    e.fv   = efv;
    e.ec   = eec;
    e.cyc  = (s < 3'd6) ? cyc + RUN_LAT : cyc;
    exp_q.push_back(e);
  endtask

  task automatic wait_quiet();
    int n = 0;
    while (exp_q.size() != 0 && n < 60) begin
      @(posedge clk);
      n++;
    end
    if (exp_q.size() != 0) begin
      check("done_timeout", exp_q.size(), 0);
      exp_q.delete();
    end
  endtask

  task automatic check_sequence();
    for (int i = 0; i < RUN_LAT; i++) begin
      @(negedge clk);
      check("ab_step", int'({a, b}), i / (SETTLE + 1));
      check("busy_run", int'(busy), 1);
    end
  endtask

  task automatic check_all_zero(input string name);
    check(name, int'({a, b, busy, done, pass, fail_vec, err_count}), 0);
  endtask

  initial begin
    int n;
    int d0;
    rst_n = 1'b0;
    start = 1'b0;
    sel   = 3'd0;
    gmode = 0;
    #23;
    check_all_zero("reset_state");
    @(negedge clk);
    rst_n = 1'b1;

    // Correct AND, vector stepping and latency
    issue(3'd0, 0, 1'b1, 4'b0000, 3'd0);
    check_sequence();
    wait_quiet();

    // XOR gate checked as AND
    issue(3'd0, 2, 1'b0, 4'b1110, 3'd3);
    wait_quiet();

    // Stuck-at-0 checked as NAND, then a correct NAND
    issue(3'd3, 6, 1'b0, 4'b0111, 3'd3);
    wait_quiet();
    issue(3'd3, 3, 1'b1, 4'b0000, 3'd0);
    wait_quiet();

    // OR checked as NOR: every vector wrong
    issue(3'd4, 1, 1'b0, 4'b1111, 3'd4);
    wait_quiet();
    // Correct XNOR
    issue(3'd5, 5, 1'b1, 4'b0000, 3'd0);
    wait_quiet();

    // Invalid sel values: immediate done, busy never high
    issue(3'd7, 0, 1'b0, 4'b1111, 3'd4);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("invalid_busy", int'(busy), 0);
      check("invalid_ab", int'({a, b}), 0);
    end
    wait_quiet();
    issue(3'd6, 0, 1'b0, 4'b1111, 3'd4);
    wait_quiet();

    // Reset during vector 10
    issue(3'd0, 0, 1'b1, 4'b0000, 3'd0);
    n = 0;
    while ({a, b} != 2'b10 && n < 30) begin
      @(negedge clk);
      n++;
    end
    check("reach_vec10", int'({a, b}), 2);
    #2;
    rst_n = 1'b0;
    #1;
    check_all_zero("async_reset");
    exp_q.delete();
    @(negedge clk);
    check_all_zero("reset_held");
    rst_n = 1'b1;
    issue(3'd0, 0, 1'b1, 4'b0000, 3'd0);
    check_sequence();
    wait_quiet();

    // Start re-pulsed mid-run with another sel: must be ignored
    d0 = done_cnt;
    issue(3'd1, 1, 1'b1, 4'b0000, 3'd0);
    repeat (4) @(negedge clk);
    sel   = 3'd0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_quiet();
    repeat (4) @(negedge clk);
    check("single_done", done_cnt - d0, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

endmodule

// File: doc/gate_checker.md
GATE_CHECKER -- requirements
Module: gate_checker

Interface
REQ-001 Parameter: SETTLE, default 2, number of wait cycles after each new input vector before y is sampled (legal range 0..15).
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 start  input  1  one-cycle request to begin a check run; honoured only in IDLE.
REQ-005 sel  input  3  expected gate function: 0 AND, 1 OR, 2 XOR, 3 NAND, 4 NOR, 5 XNOR, 6..7 invalid.
REQ-006 a  output  1  registered stimulus to the gate under test, vector MSB.
REQ-007 b  output  1  registered stimulus to the gate under test, vector LSB.
REQ-008 y  input  1  combinational response of the gate under test.
REQ-009 busy  output  1  high while a run is in progress.
REQ-010 done  output  1  one-cycle pulse marking the end of a run.
REQ-011 pass  output  1  run result: 1 only if all four vectors matched; held until the next accepted start.
REQ-012 fail_vec  output  4  bit i set when vector {a,b}=i mismatched; held until the next accepted start.
REQ-013 err_count  output  3  number of set bits in fail_vec (0..4); held until the next accepted start.

Function
REQ-014 The block SHALL implement FSM states IDLE, RUN and DONE.
REQ-015 IDLE: start=1 with a valid sel SHALL latch sel, clear pass/fail_vec/err_count, set vector index to 0 and settle count to 0, drive {a,b}=2'b00, and go to RUN on the same edge.
REQ-016 IDLE: start=1 with sel of 6 or 7 SHALL go directly to DONE with pass=0, fail_vec=4'b1111 and err_count=4; a and b SHALL stay 0.
REQ-017 RUN: while the settle count is less than SETTLE, it SHALL increment by 1 each cycle, and a and b SHALL hold.
REQ-018 RUN: on the edge where the settle count equals SETTLE, the block SHALL sample y and compare it with the latched function of the current a and b.
REQ-019 On a mismatch at that sample edge, the block SHALL set fail_vec[index] and increment err_count.
REQ-020 If the index is below 3 at that sample edge, the block SHALL increment the index, drive {a,b} to the new index and reset the settle count to 0.
REQ-021 If the index is 3 at that sample edge, the block SHALL go to DONE and drive a=b=0.
REQ-022 Vector order SHALL be {a,b} = 00, 01, 10, 11, and each vector SHALL be held for exactly SETTLE+1 cycles.
REQ-023 SETTLE=0 SHALL be legal; in that case y is sampled in the first cycle each vector is driven.
REQ-024 DONE SHALL last exactly one cycle with done=1 and SHALL then return to IDLE.
REQ-025 On entry to DONE, pass SHALL be set to 1 if and only if fail_vec==0.
REQ-026 Latency: for a valid run, done SHALL be high in the cycle after edge 4*(SETTLE+1), counting the start-accepting edge as edge 0.
REQ-027 Latency: for an invalid sel, done SHALL be high in the cycle after the start-accepting edge.
REQ-028 busy SHALL be 1 exactly while in RUN.
REQ-029 start asserted in RUN or DONE SHALL be ignored; the latched sel SHALL not change during a run.
REQ-030 A start held high for several cycles SHALL begin a new run only when the FSM is in IDLE.
REQ-031 err_count SHALL never exceed 4 and SHALL always equal the number of set bits in fail_vec.

Reset
REQ-032 rst_n=0 SHALL force IDLE asynchronously, at any time including mid-run.
REQ-033 Reset SHALL force a=0, b=0, busy=0, done=0, pass=0, fail_vec=0, err_count=0, and clear the index, settle count and latched sel.
REQ-034 After rst_n is released, the block SHALL accept start on the first rising edge at which start=1.

Verification
REQ-035 The bench SHALL cover: SETTLE=2, correct AND gate, sel=0, start pulse -> {a,b} steps 00,01,10,11 every 3 cycles; done in the cycle after edge 12; pass=1; fail_vec=0000; err_count=0.
REQ-036 The bench SHALL cover: XOR gate wired with sel=0 -> pass=0, fail_vec=1110, err_count=3.
REQ-037 The bench SHALL cover: y stuck at 0 with sel=3 (NAND) -> pass=0, fail_vec=0111, err_count=3; then a correct NAND run -> pass=1, fail_vec=0000.
REQ-038 The bench SHALL cover: sel=7 with start -> done in the cycle after the start edge; pass=0; fail_vec=1111; err_count=4; busy never asserted.
REQ-039 The bench SHALL cover: rst_n low during vector 10 -> all outputs are 0 immediately; a following start runs the full sequence from 00.
REQ-040 The bench SHALL cover: start re-pulsed during RUN with a different sel -> ignored; the result matches the originally latched sel; exactly one done pulse.
